// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller.
// Moore outputs from state; mem_ready qualifies FETCH/MEMRD/MEMWR.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_code,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCEn,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               Jal,
  output logic               Lui,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IEXEC   = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    JAL     = 4'd12,
    LUI     = 4'd13,
    ILLEGAL = 4'd14,
    UNUSED  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  state_t     st;
  state_t     nxt;
  logic [5:0] op_q;
  logic       pcwrite;
  logic       branch;

  // State register; opcode is latched in DECODE so later IR changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= FETCH;
      op_q <= 6'd0;
    end else begin
      st <= nxt;
      if (st == DECODE) op_q <= op_code;
    end
  end

  assign state = STATE_W'(st);

  // Next-state and Moore output decode; reset blanks every output at once
  always_comb begin
    nxt        = st;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    Jal        = 1'b0;
    Lui        = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    PCEn       = 1'b0;
    unique case (st)
      FETCH: begin
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (op_code)
          OP_R:    nxt = EXEC;
          OP_LW:   nxt = MEMADR;
          OP_SW:   nxt = MEMADR;
          OP_BEQ:  nxt = BRANCH;
          OP_ADDI: nxt = IEXEC;
          OP_ANDI: nxt = IEXEC;
          OP_ORI:  nxt = IEXEC;
          OP_SLTI: nxt = IEXEC;
          OP_J:    nxt = JUMP;
          OP_JAL:  nxt = JAL;
          OP_LUI:  nxt = LUI;
          default: nxt = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
        nxt     = IWB;
      end
      IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      JAL: begin
        PCSrc      = 2'b10;
        pcwrite    = 1'b1;
        RegWrite   = 1'b1;
        Jal        = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      LUI: begin
        RegWrite   = 1'b1;
        Lui        = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      default: nxt = FETCH;
    endcase
    PCEn = pcwrite | (branch & zero);
    if (reset) begin
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSrc      = 2'b00;
      Jal        = 1'b0;
      Lui        = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table,
// reset-abort sequence, and random instruction streams vs a model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, Jal, Lui, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .PCEn(PCEn), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .Jal(Jal),
    .Lui(Lui), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  // {PCEn IorD MemWrite IRWrite}_{RegDst MemtoReg RegWrite ALUSrcA}
  // _ALUSrcB_ALUOp_PCSrc_{Jal Lui instr_done illegal_op}
  function automatic logic [17:0] outs();
    return {PCEn, IorD, MemWrite, IRWrite,
            RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc,
            Jal, Lui, instr_done, illegal_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [17:0] o);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  localparam logic [17:0] O_FETCH = 18'b1001_0000_01_00_00_0000;
  localparam logic [17:0] O_FWAIT = 18'b0000_0000_01_00_00_0000;
  localparam logic [17:0] O_DEC   = 18'b0000_0000_11_00_00_0000;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic [5:0] op;
  } cyc_t;

  logic [5:0] legal [11] = '{6'b000000, 6'b100011, 6'b101011,
                             6'b000100, 6'b001000, 6'b001100,
                             6'b001101, 6'b001010, 6'b000010,
                             6'b000011, 6'b001111};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    cyc_t q[$];
    logic [5:0] op;
    int wf, wm, z, n_rw, n_mw, n_pc, n_ir, n_il, n_dn, last_dn, mis;
    int e_rw, e_mw, e_pc, e_il;

    // R-type, zero wait states
    add(6'o00, 0, 1, 0, O_FETCH);
    add(6'o00, 0, 1, 1, O_DEC);
    add(6'o00, 0, 1, 6, 18'b0000_0001_00_10_00_0000);
    add(6'o00, 0, 1, 7, 18'b0000_1010_00_00_00_0010);
    // lw, two fetch waits and one memory wait
    add(6'b100011, 0, 0, 0, O_FWAIT);
    add(6'b100011, 0, 0, 0, O_FWAIT);
    add(6'b100011, 0, 1, 0, O_FETCH);
    add(6'b100011, 0, 1, 1, O_DEC);
    add(6'b100011, 0, 1, 2, 18'b0000_0001_10_00_00_0000);
    add(6'b100011, 0, 0, 3, 18'b0100_0000_00_00_00_0000);
    add(6'b100011, 0, 1, 3, 18'b0100_0000_00_00_00_0000);
    add(6'b100011, 0, 1, 4, 18'b0000_0110_00_00_00_0010);
    // beq taken, then not taken
    add(6'b000100, 1, 1, 0, O_FETCH);
    add(6'b000100, 1, 1, 1, O_DEC);
    add(6'b000100, 1, 1, 8, 18'b1000_0001_00_01_01_0010);
    add(6'b000100, 0, 1, 0, O_FETCH);
    add(6'b000100, 0, 1, 1, O_DEC);
    add(6'b000100, 0, 1, 8, 18'b0000_0001_00_01_01_0010);
    // andi with opcode toggled in IEXEC, then addi
    add(6'b001100, 0, 1, 0, O_FETCH);
    add(6'b001100, 0, 1, 1, O_DEC);
    add(6'b000000, 0, 1, 9, 18'b0000_0001_10_11_00_0000);
    add(6'b000000, 0, 1, 10, 18'b0000_0010_00_00_00_0010);
    add(6'b001000, 0, 1, 0, O_FETCH);
    add(6'b001000, 0, 1, 1, O_DEC);
    add(6'b001000, 0, 1, 9, 18'b0000_0001_10_00_00_0000);
    add(6'b001000, 0, 1, 10, 18'b0000_0010_00_00_00_0010);
    // jal
    add(6'b000011, 0, 1, 0, O_FETCH);
    add(6'b000011, 0, 1, 1, O_DEC);
    add(6'b000011, 0, 1, 12, 18'b1000_0010_00_00_10_1010);
    // illegal opcode
    add(6'b111111, 0, 1, 0, O_FETCH);
    add(6'b111111, 0, 1, 1, O_DEC);
    add(6'b111111, 0, 1, 14, 18'b0000_0000_00_00_00_0011);
    // sw with one memory wait
    add(6'b101011, 0, 1, 0, O_FETCH);
    add(6'b101011, 0, 1, 1, O_DEC);
    add(6'b101011, 0, 1, 2, 18'b0000_0001_10_00_00_0000);
    add(6'b101011, 0, 0, 5, 18'b0110_0000_00_00_00_0000);
    add(6'b101011, 0, 1, 5, 18'b0110_0000_00_00_00_0010);
    // j and lui
    add(6'b000010, 0, 1, 0, O_FETCH);
    add(6'b000010, 0, 1, 1, O_DEC);
    add(6'b000010, 0, 1, 11, 18'b1000_0000_00_00_10_0010);
    add(6'b001111, 0, 1, 0, O_FETCH);
    add(6'b001111, 0, 1, 1, O_DEC);
    add(6'b001111, 0, 1, 13, 18'b0000_0010_00_00_00_0110);

    // reset held with FETCH-like inputs: everything must read 0
    reset = 1'b1; op_code = 6'd0; zero = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(outs()), 32'd0);
    tick();
    reset = 1'b0;

    foreach (tbl[i]) begin
      op_code = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].o));
      tick();
    end

    // reset during a stalled store aborts the write strobe at once
    op_code = 6'b101011; zero = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("memwr_state", 32'(state), 32'd5);
    chk("memwr_strobe", 32'(MemWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_strobe", 32'(MemWrite), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_outs", 32'(outs()), 32'd0);
    tick();
    reset = 1'b0; mem_ready = 1'b1; op_code = 6'd0;
    @(negedge clk);
    chk("resume_state", 32'(state), 32'd0);
    chk("resume_irwrite", 32'(IRWrite), 32'd1);
    tick();
    @(negedge clk);
    chk("resume_decode", 32'(state), 32'd1);
    tick();
    tick();
    tick();

    // random instruction stream against the instruction-level model
    for (int n = 0; n < 200; n++) begin
      int k;
      k = $urandom_range(0, 11);
      if (k == 11) begin
        do op = 6'($urandom); while (is_legal(op));
      end else op = legal[k];
      wf = $urandom_range(0, 2);
      wm = $urandom_range(0, 2);
      z = $urandom_range(0, 1);
      q.delete();
      for (int i = 0; i < wf; i++) q.push_back('{4'd0, 1'b0, op});
      q.push_back('{4'd0, 1'b1, op});
      q.push_back('{4'd1, 1'($urandom), op});
      e_rw = 0; e_mw = 0; e_pc = 1; e_il = 0;
      case (op)
        6'b000000: begin
          q.push_back('{4'd6, 1'($urandom), 6'($urandom)});
          q.push_back('{4'd7, 1'($urandom), 6'($urandom)});
          e_rw = 1;
        end
        6'b100011: begin
          q.push_back('{4'd2, 1'($urandom), 6'($urandom)});
          for (int i = 0; i < wm; i++) q.push_back('{4'd3, 1'b0, 6'($urandom)});
          q.push_back('{4'd3, 1'b1, 6'($urandom)});
          q.push_back('{4'd4, 1'($urandom), 6'($urandom)});
          e_rw = 1;
        end
        6'b101011: begin
          q.push_back('{4'd2, 1'($urandom), 6'($urandom)});
          for (int i = 0; i < wm; i++) q.push_back('{4'd5, 1'b0, 6'($urandom)});
          q.push_back('{4'd5, 1'b1, 6'($urandom)});
          e_mw = wm + 1;
        end
        6'b000100: begin
          q.push_back('{4'd8, 1'($urandom), 6'($urandom)});
          e_pc = 1 + z;
        end
        6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
          q.push_back('{4'd9, 1'($urandom), 6'($urandom)});
          q.push_back('{4'd10, 1'($urandom), 6'($urandom)});
          e_rw = 1;
        end
        6'b000010: begin
          q.push_back('{4'd11, 1'($urandom), 6'($urandom)});
          e_pc = 2;
        end
        6'b000011: begin
          q.push_back('{4'd12, 1'($urandom), 6'($urandom)});
          e_pc = 2; e_rw = 1;
        end
        6'b001111: begin
          q.push_back('{4'd13, 1'($urandom), 6'($urandom)});
          e_rw = 1;
        end
        default: begin
          q.push_back('{4'd14, 1'($urandom), 6'($urandom)});
          e_il = 1;
        end
      endcase
      n_rw = 0; n_mw = 0; n_pc = 0; n_ir = 0; n_il = 0; n_dn = 0;
      last_dn = 0; mis = 0;
      zero = 1'(z);
      foreach (q[i]) begin
        op_code = q[i].op; mem_ready = q[i].mr;
        @(negedge clk);
        if (state !== q[i].st) mis++;
        n_rw += int'(RegWrite); n_mw += int'(MemWrite);
        n_pc += int'(PCEn); n_ir += int'(IRWrite);
        n_il += int'(illegal_op); n_dn += int'(instr_done);
        if (i == q.size() - 1) last_dn = int'(instr_done);
        tick();
      end
      chk($sformatf("r%0d_op%0h_states", n, op), 32'(mis), 32'd0);
      chk($sformatf("r%0d_regwrite", n), 32'(n_rw), 32'(e_rw));
      chk($sformatf("r%0d_memwrite", n), 32'(n_mw), 32'(e_mw));
      chk($sformatf("r%0d_pcen", n), 32'(n_pc), 32'(e_pc));
      chk($sformatf("r%0d_irwrite", n), 32'(n_ir), 32'd1);
      chk($sformatf("r%0d_illegal", n), 32'(n_il), 32'(e_il));
      chk($sformatf("r%0d_done_cnt", n), 32'(n_dn), 32'd1);
      chk($sformatf("r%0d_done_last", n), 32'(last_dn), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle MIPS datapath, replacing the single-cycle decoder.
- Steps each instruction through fetch, decode, execute, memory and writeback states, one datapath operation per cycle, and drives all datapath mux selects and write enables.
- Supports R-type, lw, sw, beq, addi, andi, ori, slti, j, jal and lui.
- Provides a memory-ready handshake and per-instruction completion and illegal-opcode pulses.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- op_code  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCEn  out  1  PC register enable; equals PCWrite | (Branch & zero).
- IorD  out  1  memory address select; 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write-register select; 1 = rd, 0 = rt.
- MemtoReg  out  1  write-data select; 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select; 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  out  2  to ALU decoder; 00 = add, 01 = sub, 10 = funct, 11 = immediate-logic.
- PCSrc  out  2  next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- Jal  out  1  write register 31 with the PC value.
- Lui  out  1  write data is imm<<16.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- state  out  STATE_W  current state, for debug.

Behaviour:
- State register and op_q (6 bits) are updated on posedge clk or posedge reset.
- Reset: state = FETCH, op_q = 0. While reset is high, every output is forced to 0 except state, which reads 0.
- Outputs are Moore-decoded from state (and op_q in IEXEC), except the mem_ready qualification noted below. Any signal not listed for a state is 0.
- State encoding, outputs and next state:
  - 0 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite are asserted only when mem_ready=1. Goes to DECODE when mem_ready=1, otherwise holds.
  - 1 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. op_q is loaded from op_code. Next state by op_code: 000000→EXEC; 100011/101011→MEMADR; 000100→BRANCH; 001000/001100/001101/001010→IEXEC; 000010→JUMP; 000011→JAL; 001111→LUI; any other→ILLEGAL.
  - 2 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if op_q=lw, else MEMWR.
  - 3 MEMRD: IorD=1. Goes to MEMWB when mem_ready=1, else holds.
  - 4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
  - 5 MEMWR: IorD=1, MemWrite=1, held asserted until mem_ready=1. Goes to FETCH when mem_ready=1.
  - 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - 7 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Goes to FETCH.
  - 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, so PCEn=zero. Goes to FETCH.
  - 9 IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 if op_q=addi, 11 for andi/ori/slti. Goes to IWB.
  - 10 IWB: RegDst=0, MemtoReg=0, RegWrite=1. Goes to FETCH.
  - 11 JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
  - 12 JAL: PCSrc=10, PCWrite=1, RegWrite=1, Jal=1. Register 31 receives the pre-edge PC (PC+4). Goes to FETCH.
  - 13 LUI: RegDst=0, RegWrite=1, Lui=1. Goes to FETCH.
  - 14 ILLEGAL: illegal_op=1, no write enables asserted. Goes to FETCH.
  - 15 unused: all outputs 0. Goes to FETCH.
- instr_done is 1 in any state whose next state is FETCH, including MEMWR only when mem_ready=1, and ILLEGAL.
- Cycle counts with zero wait states: lw 5; sw, R-type and I-ALU 4; beq, j, jal and lui 3.
- Each wait cycle adds one cycle (FETCH, MEMRD, MEMWR only). mem_ready is ignored in all other states.
- Reset asserted mid-instruction aborts it immediately; no partial write strobe is issued after reset rises. The FSM resumes at FETCH on the first clock edge after reset falls.
- op_code changing after DECODE has no effect; op_q is used thereafter.

Test Plan:
- Reset held, then released with mem_ready=1 and op_code=000000 → state sequence 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_done pulses once. Four cycles total.
- lw with mem_ready low for 2 cycles in FETCH and 1 in MEMRD → sequence 0,0,0,1,2,3,3,4,0. IRWrite pulses only on the third FETCH cycle. MemtoReg=1 in state 4.
- beq with zero=1, then beq with zero=0 → PCEn=1 in BRANCH for the first and 0 for the second. ALUOp=01 and PCSrc=01 in both.
- andi (001100) then addi (001000) → ALUOp=11 then 00 in IEXEC. op_code toggled to 000000 during IEXEC does not change ALUOp.
- jal (000011) → state 12 with PCEn=1, RegWrite=1, Jal=1, PCSrc=10. Next state FETCH.
- op_code=111111 → ILLEGAL with illegal_op=1 and RegWrite=MemWrite=PCEn=0. Reset asserted during MEMWR → MemWrite drops to 0 at once and state=0.
